// File: rtl/instr_ram_loadable.sv
// Loadable instruction RAM: registered fetch port for the control unit plus a
// valid/ready program-load port with running XOR checksum and bounds checking.
module instr_ram_loadable #(
  parameter int               DATA_W    = 16,
  parameter int               OPCODE_W  = 6,
  parameter int               ADDR_W    = 9,
  parameter int               DEPTH     = 201,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'hB800,
  parameter                   INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [DATA_W-1:0] checksum
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  generate
    if (OPCODE_W >= DATA_W || DEPTH > (1 << ADDR_W) || IDX_W > ADDR_W) begin : g_bad_cfg
      $error("instr_ram_loadable: inconsistent OPCODE_W/DEPTH/ADDR_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_RUN, S_LOAD, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W:0]   remaining;
  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  // Power-up contents only; reset deliberately leaves the array untouched.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = NOP_WORD;
  end

  // Load-control FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    load_ready = 1'b0;
    load_busy  = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (load_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_busy  = 1'b1;
        load_ready = (remaining != '0);
        if (remaining == '0) begin
          state_d = S_DONE;
        end else if (load_valid) begin
          accept = 1'b1;
          if (remaining == (ADDR_W + 1)'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        load_busy = 1'b1;
        load_done = 1'b1;
        state_d   = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Session bookkeeping: write pointer, word budget, checksum, sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      waddr     <= '0;
      remaining <= '0;
      checksum  <= '0;
      load_err  <= 1'b0;
    end else if (state_q == S_RUN && load_start) begin
      waddr     <= load_base;
      remaining <= load_len;
      checksum  <= '0;
      load_err  <= 1'b0;
    end else if (accept) begin
      waddr     <= waddr + 1'b1;
      remaining <= remaining - 1'b1;
      checksum  <= checksum ^ load_data;
      if (!in_range(waddr)) load_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_range(waddr)) mem[waddr[IDX_W-1:0]] <= load_data;
  end

  // Fetch stage: one-cycle registered read, stalled outside RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (state_q != S_RUN) begin
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else if (in_range(address)) begin
      instr_out   <= mem[address[IDX_W-1:0]];
      instr_valid <= 1'b1;
      fetch_err   <= 1'b0;
    end else begin
      instr_out   <= NOP_WORD;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_ram_loadable.sv
// Bench for instr_ram_loadable: directed sessions, a fetch vector table and
// randomized load sessions checked against an array-based reference memory.
module tb_instr_ram_loadable;

  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 9;
  localparam int          DEPTH  = 201;
  localparam logic [15:0] NOP    = 16'hB800;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] instr_out;
  logic              instr_valid, fetch_err;
  logic              load_start = 1'b0;
  logic [ADDR_W-1:0] load_base = '0;
  logic [ADDR_W:0]   load_len = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              load_valid = 1'b0;
  logic              load_ready, load_busy, load_done, load_err;
  logic [DATA_W-1:0] checksum;

  instr_ram_loadable #(
    .DATA_W(DATA_W), .OPCODE_W(6), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .NOP_WORD(NOP), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .address(address), .instr_out(instr_out),
    .instr_valid(instr_valid), .fetch_err(fetch_err), .load_start(load_start),
    .load_base(load_base), .load_len(load_len), .load_data(load_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: what memory should hold, and the session results.
  logic [15:0] model_mem [DEPTH];
  logic [15:0] model_csum;
  logic        model_err;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       exp_instr;
    logic              exp_valid;
    logic              exp_err;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_check(input logic [ADDR_W-1:0] a, input string tag);
    address = a;
    tick();
    if (int'(a) < DEPTH) begin
      chk({tag, "_instr"}, 32'(instr_out), 32'(model_mem[a]));
      chk({tag, "_valid"}, 32'(instr_valid), 1);
      chk({tag, "_err"}, 32'(fetch_err), 0);
    end else begin
      chk({tag, "_instr"}, 32'(instr_out), 32'(NOP));
      chk({tag, "_valid"}, 32'(instr_valid), 0);
      chk({tag, "_err"}, 32'(fetch_err), 1);
    end
  endtask

  // mode: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid
  task automatic run_session(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                             input logic [15:0] data[$], input int mode, input bit restart);
    int acc = 0;
    int cyc = 0;
    bit v;
    logic [ADDR_W-1:0] wa;
    model_csum = '0;
    model_err  = 1'b0;
    load_base  = base;
    load_len   = len;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_base  = ADDR_W'($urandom);
    load_len   = (ADDR_W + 1)'($urandom);
    chk("busy_in_load", 32'(load_busy), 1);
    while (acc < int'(len) && cyc < 200) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      load_valid = v;
      load_data  = v ? data[acc] : 16'($urandom);
      address    = ADDR_W'($urandom);
      if (restart && cyc == 1) begin
        load_start = 1'b1;
        load_base  = base + 9'd37;
        load_len   = 10'd1;
      end
      #1;
      chk("ready_in_load", 32'(load_ready), 1);
      chk("no_early_done", 32'(load_done), 0);
      if (v) begin
        wa = base + ADDR_W'(acc);
        if (int'(wa) < DEPTH) model_mem[wa] = data[acc];
        else                  model_err = 1'b1;
        model_csum ^= data[acc];
        acc++;
      end
      tick();
      load_start = 1'b0;
      chk("stall_valid", 32'(instr_valid), 0);
      chk("stall_err", 32'(fetch_err), 0);
      cyc++;
    end
    if (cyc >= 200) chk("session_timeout", 32'(acc), 32'(len));
    load_valid = 1'b0;
    if (len == '0) begin
      #1;
      chk("ready_len0", 32'(load_ready), 0);
      chk("busy_len0", 32'(load_busy), 1);
      tick();
    end
    chk("done_pulse", 32'(load_done), 1);
    chk("done_ready", 32'(load_ready), 0);
    chk("done_busy", 32'(load_busy), 1);
    chk("checksum", 32'(checksum), 32'(model_csum));
    chk("load_err", 32'(load_err), 32'(model_err));
    tick();
    chk("done_cleared", 32'(load_done), 0);
    chk("busy_cleared", 32'(load_busy), 0);
    chk("checksum_hold", 32'(checksum), 32'(model_csum));
  endtask

  initial begin
    logic [15:0] d[$];

    tbl[0]  = '{9'd10,  16'h0800, 1'b1, 1'b0};
    tbl[1]  = '{9'd11,  16'h1C00, 1'b1, 1'b0};
    tbl[2]  = '{9'd12,  16'hB800, 1'b1, 1'b0};
    tbl[3]  = '{9'd0,   16'h1111, 1'b1, 1'b0};
    tbl[4]  = '{9'd1,   16'h2222, 1'b1, 1'b0};
    tbl[5]  = '{9'd2,   16'h3333, 1'b1, 1'b0};
    tbl[6]  = '{9'd3,   16'h4444, 1'b1, 1'b0};
    tbl[7]  = '{9'd4,   16'hB800, 1'b1, 1'b0};
    tbl[8]  = '{9'd199, 16'hA001, 1'b1, 1'b0};
    tbl[9]  = '{9'd200, 16'hA002, 1'b1, 1'b0};
    tbl[10] = '{9'd201, 16'hB800, 1'b0, 1'b1};
    tbl[11] = '{9'd300, 16'hB800, 1'b0, 1'b1};

    for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;

    // Reset state
    tick();
    tick();
    chk("rst_instr", 32'(instr_out), 32'(NOP));
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_ferr", 32'(fetch_err), 0);
    chk("rst_ready", 32'(load_ready), 0);
    chk("rst_busy", 32'(load_busy), 0);
    chk("rst_done", 32'(load_done), 0);
    chk("rst_lerr", 32'(load_err), 0);
    chk("rst_csum", 32'(checksum), 0);
    rst = 1'b0;
    tick();

    for (int a = 0; a < 4; a++) fetch_check(ADDR_W'(a), $sformatf("init%0d", a));

    // Three words back-to-back
    d = '{16'h0800, 16'h1C00, 16'hB800};
    run_session(9'd10, 10'd3, d, 0, 1'b0);
    chk("csum_three_words", 32'(checksum), 32'h0000AC00);

    // Valid toggling every other cycle
    d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_session(9'd0, 10'd4, d, 1, 1'b0);

    // Straddling the end of the implemented range
    d = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    run_session(9'd199, 10'd4, d, 0, 1'b0);
    chk("lerr_sticky", 32'(load_err), 1);

    for (int i = 0; i < 12; i++) begin
      address = tbl[i].addr;
      tick();
      chk($sformatf("tbl%0d_instr", i), 32'(instr_out), 32'(tbl[i].exp_instr));
      chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_ferr", i), 32'(fetch_err), 32'(tbl[i].exp_err));
    end

    // Write pointer wrapping past 2^ADDR_W back into range
    d = '{16'h5A01, 16'h5A02, 16'h5A03, 16'h5A04};
    run_session(9'd510, 10'd4, d, 0, 1'b0);
    fetch_check(9'd0, "wrap0");
    fetch_check(9'd1, "wrap1");

    // Zero-length session and ignored restart request
    d = {};
    run_session(9'd77, 10'd0, d, 0, 1'b0);
    d = '{16'h0123, 16'h4567, 16'h89AB};
    run_session(9'd20, 10'd3, d, 0, 1'b1);

    // Reset in the middle of a five-word session
    d = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005};
    load_base  = 9'd50;
    load_len   = 10'd5;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = d[i];
      model_mem[50 + i] = d[i];
      tick();
    end
    load_data = d[2];
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(load_busy), 0);
    chk("midrst_ready", 32'(load_ready), 0);
    chk("midrst_done", 32'(load_done), 0);
    chk("midrst_csum", 32'(checksum), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_no_done", 32'(load_done), 0);
    chk("midrst_idle", 32'(load_busy), 0);
    load_valid = 1'b0;
    for (int a = 50; a < 55; a++) fetch_check(ADDR_W'(a), $sformatf("midrst%0d", a));

    // Randomized sessions followed by random fetches
    for (int s = 0; s < 15; s++) begin
      logic [ADDR_W-1:0] b;
      logic [ADDR_W:0]   n;
      d = {};
      b = ($urandom_range(0, 2) == 0) ? ADDR_W'($urandom_range(190, 511))
                                      : ADDR_W'($urandom_range(0, 200));
      n = (ADDR_W + 1)'($urandom_range(0, 8));
      for (int k = 0; k < int'(n); k++) d.push_back(16'($urandom));
      run_session(b, n, d, 2, 1'($urandom_range(0, 1)));
    end
    for (int f = 0; f < 40; f++) fetch_check(ADDR_W'($urandom), $sformatf("rnd%0d", f));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
